// File: rtl/conv_tap_streamer.sv
// conv_tap_streamer
// Producer side of the convolution product stream. Takes one 3x3 pixel
// window per handshake and emits TAPS signed products (pixel * stored
// kernel coefficient) serially, one per downstream beat, with last framing.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   win_pix    window pixels, tap k at [k*PIX_W +: PIX_W], raster order
//   win_valid  window present
//   win_ready  window accepted when win_valid && win_ready
//   coef_data  signed kernel coefficients, tap k at [k*COEF_W +: COEF_W]
//   coef_load  load coef_data into the coefficient registers
//   coef_drop  one-cycle pulse: coef_load ignored because a window is in flight
//   out_prod   signed product of the current tap
//   out_valid  out_prod valid
//   out_last   marks tap TAPS-1 of the window
//   out_ready  downstream accepts beat when out_valid && out_ready
//   busy       high while streaming a window
//
// state  | meaning
// IDLE   | no window held, waiting for win_valid (coefficients may load)
// STREAM | emitting the taps of the held window

module conv_tap_streamer #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 5,
    parameter int TAPS   = 9,
    localparam int PROD_W = PIX_W + COEF_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TAPS*PIX_W-1:0]    win_pix,
    input  logic                     win_valid,
    output logic                     win_ready,
    input  logic [TAPS*COEF_W-1:0]   coef_data,
    input  logic                     coef_load,
    output logic                     coef_drop,
    output logic [PROD_W-1:0]        out_prod,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [PIX_W-1:0]          r_win  [TAPS];
    logic signed [COEF_W-1:0]  r_coef [TAPS];
    logic signed [PROD_W-1:0]  r_prod;
    logic                      r_valid;
    logic                      r_last;
    logic                      r_drop;

    logic                      w_boundary;
    logic                      w_accept;
    logic [IDX_W-1:0]          w_nidx;
    logic signed [PROD_W-1:0]  w_prod_first;
    logic signed [PROD_W-1:0]  w_prod_next;

    // Pixel is zero-extended to make it signed; PROD_W is wide enough that
    // the product is exact for every pixel/coefficient pair.
    function automatic logic signed [PROD_W-1:0] tap_prod(
        input logic [PIX_W-1:0]         pix,
        input logic signed [COEF_W-1:0] coef
    );
        logic signed [PIX_W:0] w_spix;
        w_spix = {1'b0, pix};
        return PROD_W'(w_spix) * PROD_W'(coef);
    endfunction

    // Last beat being taken this cycle: the only STREAM cycle where a new
    // window or a new coefficient set may come in.
    assign w_boundary = (r_state == STREAM) && r_valid && r_last && out_ready;
    assign win_ready  = !rst && !coef_load && ((r_state == IDLE) || w_boundary);
    assign w_accept   = win_valid && win_ready;

    // Clamp avoids indexing past the window on the last tap.
    assign w_nidx       = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
    assign w_prod_first = tap_prod(win_pix[PIX_W-1:0], r_coef[0]);
    assign w_prod_next  = tap_prod(r_win[w_nidx], r_coef[w_nidx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_prod  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_drop  <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
                r_win[k]  <= '0;
            end
        end else begin
            r_drop <= 1'b0;
            if (coef_load) begin
                if ((r_state == IDLE) || w_boundary) begin
                    for (int k = 0; k < TAPS; k++) begin
                        r_coef[k] <= coef_data[k*COEF_W +: COEF_W];
                    end
                end else begin
                    r_drop <= 1'b1;
                end
            end

            if (w_accept) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_win[k] <= win_pix[k*PIX_W +: PIX_W];
                end
                r_prod  <= w_prod_first;
                r_valid <= 1'b1;
                r_last  <= (TAPS == 1);
                r_idx   <= '0;
                r_state <= STREAM;
            end else if ((r_state == STREAM) && r_valid && out_ready) begin
                if (r_last) begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= IDLE;
                end else begin
                    r_prod <= w_prod_next;
                    r_idx  <= w_nidx;
                    r_last <= (w_nidx == LAST_IDX);
                end
            end
        end
    end

    assign out_prod  = r_prod;
    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign coef_drop = r_drop;
    assign busy      = (r_state == STREAM);

endmodule
